// File: rtl/cmd_frame_serializer_if.sv
// Command-word handshake between the command source and the frame serializer.
// The source drives a word and valid; the serializer pulses ready when it takes the word.
interface cmd_frame_serializer_if;
  logic [15:0] DATA_IN;
  logic        DATA_VALID;
  logic        DATA_READY;

  modport master (output DATA_IN, output DATA_VALID, input DATA_READY);
  modport slave  (input DATA_IN, input DATA_VALID, output DATA_READY);
endinterface

// File: rtl/cmd_frame_serializer.sv
// MSB-first 16-bit command frame serializer feeding LVDS_CMD.
// Emits init SYNCs after reset, forced periodic SYNCs, data words, and IDLE fill.
module cmd_frame_serializer #(
  parameter logic [15:0] SYNC_WORD   = 16'h817E,
  parameter logic [15:0] IDLE_WORD   = 16'hAAAA,
  parameter int unsigned SYNC_PERIOD = 32,
  parameter int unsigned INIT_SYNCS  = 8
) (
  input  logic                   CMD_CLK,
  input  logic                   RST,
  cmd_frame_serializer_if.slave  cmd,
  output logic                   CMD_OUT,
  output logic                   FRAME_START,
  output logic [1:0]             FRAME_TYPE,
  output logic                   INIT_DONE,
  output logic                   BUSY
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = 4;
  localparam logic [1:0]  TYPE_IDLE = 2'd0;
  localparam logic [1:0]  TYPE_SYNC = 2'd1;
  localparam logic [1:0]  TYPE_DATA = 2'd2;

  logic [15:0]      shreg_q, shreg_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic [1:0]       frame_type_q, frame_type_d;
  logic             frame_start_q, frame_start_d;
  logic             init_done_q, init_done_d;
  logic             busy_q, busy_d;

  logic boundary_c, init_sel_c, force_sel_c, data_sel_c;

  // Frame selection terms, evaluated only at the frame boundary.
  always_comb begin
    boundary_c  = (bit_cnt_q == BIT_W'(15));
    init_sel_c  = (init_cnt_q < CNT_W'(INIT_SYNCS));
    force_sel_c = (sync_cnt_q >= CNT_W'(SYNC_PERIOD - 1));
    data_sel_c  = boundary_c && !init_sel_c && !force_sel_c && cmd.DATA_VALID;
  end

  assign cmd.DATA_READY = data_sel_c;

  // Next-state: shift within a frame, load a new frame at the boundary.
  always_comb begin
    shreg_d       = {shreg_q[14:0], 1'b0};
    bit_cnt_d     = bit_cnt_q + BIT_W'(1);
    sync_cnt_d    = sync_cnt_q;
    init_cnt_d    = init_cnt_q;
    frame_type_d  = frame_type_q;
    frame_start_d = 1'b0;
    init_done_d   = init_done_q;
    if (boundary_c) begin
      bit_cnt_d     = '0;
      frame_start_d = 1'b1;
      if (init_sel_c) begin
        shreg_d      = SYNC_WORD;
        frame_type_d = TYPE_SYNC;
        sync_cnt_d   = '0;
        init_cnt_d   = init_cnt_q + CNT_W'(1);
      end else begin
        init_done_d = 1'b1;
        if (force_sel_c) begin
          shreg_d      = SYNC_WORD;
          frame_type_d = TYPE_SYNC;
          sync_cnt_d   = '0;
        end else if (data_sel_c) begin
          shreg_d      = cmd.DATA_IN;
          frame_type_d = TYPE_DATA;
          sync_cnt_d   = sync_cnt_q + CNT_W'(1);
        end else begin
          shreg_d      = IDLE_WORD;
          frame_type_d = TYPE_IDLE;
          sync_cnt_d   = sync_cnt_q + CNT_W'(1);
        end
      end
    end
    busy_d = (frame_type_d == TYPE_DATA);
  end

  // Reset parks bit_cnt at 15 so the first edge after release starts a clean frame.
  always_ff @(posedge CMD_CLK or posedge RST) begin
    if (RST) begin
      shreg_q       <= '0;
      bit_cnt_q     <= BIT_W'(15);
      sync_cnt_q    <= '0;
      init_cnt_q    <= '0;
      frame_type_q  <= TYPE_IDLE;
      frame_start_q <= 1'b0;
      init_done_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      sync_cnt_q    <= sync_cnt_d;
      init_cnt_q    <= init_cnt_d;
      frame_type_q  <= frame_type_d;
      frame_start_q <= frame_start_d;
      init_done_q   <= init_done_d;
      busy_q        <= busy_d;
    end
  end

  assign CMD_OUT     = shreg_q[15];
  assign FRAME_START = frame_start_q;
  assign FRAME_TYPE  = frame_type_q;
  assign INIT_DONE   = init_done_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_cmd_frame_serializer.sv
// Self-checking bench for cmd_frame_serializer: frame-level reference model plus
// serial-word scoreboard, driven by directed and randomized command traffic.
`timescale 1ns/1ps
module tb_cmd_frame_serializer;

  localparam int unsigned P     = 32;
  localparam int unsigned NINIT = 8;
  localparam logic [15:0] SYNCW = 16'h817E;
  localparam logic [15:0] IDLEW = 16'hAAAA;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_out, frame_start, init_done, busy;
  logic [1:0] frame_type;

  always #5 clk = ~clk;

  cmd_frame_serializer_if ifc ();

  cmd_frame_serializer #(
    .SYNC_WORD(SYNCW), .IDLE_WORD(IDLEW), .SYNC_PERIOD(P), .INIT_SYNCS(NINIT)
  ) dut (
    .CMD_CLK(clk), .RST(rst), .cmd(ifc),
    .CMD_OUT(cmd_out), .FRAME_START(frame_start), .FRAME_TYPE(frame_type),
    .INIT_DONE(init_done), .BUSY(busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: bit position on the line, frame word and type, counts.
  int          m_pos, m_init, m_since, m_type;
  logic [15:0] m_word;
  bit          m_init_done;

  int          mode;
  logic [15:0] src_q[$];
  logic [15:0] acc_q[$];
  int          ftypes[$];
  int          rdy_cnt, data_frames, run_obs, obs_bits, busy_cycles, cyc, first_fs;
  logic [15:0] obs_word, last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic model_reset();
    m_pos = 15; m_init = 0; m_since = 0; m_type = 0; m_word = '0;
    m_init_done = 0; run_obs = 0; obs_bits = 0; cyc = 0; first_fs = -1;
    acc_q.delete(); ftypes.delete();
  endtask

  task automatic drive();
    case (mode)
      0: ifc.DATA_VALID = 1'b0;
      1: begin
        ifc.DATA_VALID = (src_q.size() != 0);
        if (src_q.size() != 0) ifc.DATA_IN = src_q[0];
      end
      2: begin
        ifc.DATA_VALID = (src_q.size() != 0) && ($urandom_range(0, 1) == 1);
        if (src_q.size() != 0) ifc.DATA_IN = src_q[0];
      end
      default: ;
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_out"}, cmd_out, 1'b0);
    chk({tag, "_ready"}, ifc.DATA_READY, 1'b0);
    chk({tag, "_fstart"}, frame_start, 1'b0);
    chk({tag, "_ftype"}, frame_type, 2'd0);
    chk({tag, "_init_done"}, init_done, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // One clock cycle: check the handshake before the edge, then the line after it.
  task automatic step();
    logic        cur_v, exp_rdy, obs_rdy;
    logic [15:0] cur_d;
    bit          bnd;
    #1;
    cur_v   = ifc.DATA_VALID;
    cur_d   = ifc.DATA_IN;
    bnd     = (m_pos == 15);
    exp_rdy = bnd && (m_init >= NINIT) && (m_since < P - 1) && cur_v;
    obs_rdy = ifc.DATA_READY;
    chk("data_ready", obs_rdy, exp_rdy);
    if (obs_rdy === 1'b1) rdy_cnt++;
    if (exp_rdy) acc_q.push_back(cur_d);
    @(posedge clk);
    #1;
    cyc++;
    if (bnd) begin
      m_pos = 0;
      if (m_init < NINIT) begin
        m_init++; m_word = SYNCW; m_type = 1; m_since = 0;
      end else begin
        m_init_done = 1;
        if (m_since >= P - 1) begin
          m_word = SYNCW; m_type = 1; m_since = 0;
        end else if (cur_v) begin
          m_word = cur_d; m_type = 2; m_since++;
        end else begin
          m_word = IDLEW; m_type = 0; m_since++;
        end
      end
    end else begin
      m_pos++;
    end
    chk("cmd_out", cmd_out, m_word[15 - m_pos]);
    chk("frame_start", frame_start, (m_pos == 0));
    chk("frame_type", frame_type, m_type);
    chk("busy", busy, (m_type == 2));
    chk("init_done", init_done, m_init_done);

    // Observation side: sync spacing, frame log and serial word reassembly.
    if (frame_start === 1'b1) begin
      if (first_fs < 0) first_fs = cyc;
      ftypes.push_back(int'(frame_type));
      if (frame_type === 2'd1) begin
        if (init_done === 1'b1) chk("sync_spacing", run_obs, P - 1);
        run_obs = 0;
      end else begin
        run_obs++;
      end
      obs_bits = 0;
    end
    obs_word = {obs_word[14:0], cmd_out};
    obs_bits++;
    if (obs_bits == 16 && frame_type === 2'd2) begin
      data_frames++;
      last_data = obs_word;
      if (acc_q.size() == 0) timeout_fail("scoreboard_underflow");
      else chk("serial_word", obs_word, acc_q.pop_front());
    end
    if (busy === 1'b1) busy_cycles++;

    if (obs_rdy === 1'b1) begin
      if (mode == 1 || mode == 2) begin
        if (src_q.size() != 0) void'(src_q.pop_front());
      end else if (mode == 3) begin
        ifc.DATA_VALID = 1'b0;
      end
    end
    drive();
  endtask

  initial begin
    int n, r0, d0;
    bit ok;
    rst = 1'b1;
    mode = 0;
    ifc.DATA_VALID = 1'b0;
    ifc.DATA_IN = '0;
    rdy_cnt = 0; data_frames = 0; busy_cycles = 0; obs_word = '0; last_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // Reset release with no traffic: 8 init SYNCs, then IDLE with INIT_DONE.
    for (int i = 0; i < 144; i++) step();
    chk("first_fs_cycle", first_fs, 1);
    for (int i = 0; i < 8; i++) chk("init_sync_type", ftypes[i], 1);
    chk("frame9_type", ftypes[8], 0);

    // Directed word 0x1234.
    mode = 3;
    busy_cycles = 0;
    ifc.DATA_IN = 16'h1234;
    ifc.DATA_VALID = 1'b1;
    for (int i = 0; i < 40; i++) step();
    chk("busy_len_1234", busy_cycles, 16);
    chk("word_1234", last_data, 16'h1234);

    // 100 back-to-back random words.
    mode = 1;
    r0 = rdy_cnt; d0 = data_frames;
    for (int i = 0; i < 100; i++) src_q.push_back(16'($urandom()));
    drive();
    n = 0;
    while (src_q.size() != 0 && n < 4000) begin step(); n++; end
    if (n >= 4000) timeout_fail("stream_drain");
    for (int i = 0; i < 20; i++) step();
    chk("stream_ready_count", rdy_cnt - r0, 100);
    chk("stream_frames", data_frames - d0, 100);
    chk("stream_acc_empty", acc_q.size(), 0);

    // Word arriving exactly when a forced SYNC is due waits one frame.
    mode = 3;
    ifc.DATA_VALID = 1'b0;
    n = 0;
    while (!(m_since == P - 1 && m_pos == 15) && n < 1200) begin step(); n++; end
    if (n >= 1200) timeout_fail("collision_wait");
    ifc.DATA_IN = 16'($urandom());
    ifc.DATA_VALID = 1'b1;
    step();
    chk("collision_sync", frame_type, 2'd1);
    for (int i = 0; i < 16; i++) step();
    chk("collision_data", frame_type, 2'd2);
    chk("collision_fstart", frame_start, 1'b1);
    for (int i = 0; i < 16; i++) step();

    // Random valid toggling with held words.
    mode = 2;
    r0 = rdy_cnt; d0 = data_frames;
    for (int i = 0; i < 40; i++) src_q.push_back(16'($urandom()));
    drive();
    n = 0;
    while (src_q.size() != 0 && n < 6000) begin step(); n++; end
    if (n >= 6000) timeout_fail("random_drain");
    for (int i = 0; i < 20; i++) step();
    chk("random_ready_count", rdy_cnt - r0, 40);
    chk("random_frames", data_frames - d0, 40);

    // Reset pulse at bit 7 of a data frame.
    mode = 3;
    ifc.DATA_IN = 16'($urandom());
    ifc.DATA_VALID = 1'b1;
    n = 0;
    while (!(m_type == 2 && m_pos == 7) && n < 200) begin step(); n++; end
    if (n >= 200) timeout_fail("reset_wait");
    ifc.DATA_VALID = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
    end
    ifc.DATA_VALID = 1'b0;
    mode = 0;
    model_reset();
    rst = 1'b0;

    // Idle-only after reset: 8 SYNCs then (31 IDLE, 1 SYNC) repeating.
    for (int i = 0; i < 1160; i++) step();
    chk("rst_first_fs", first_fs, 1);
    ok = (ftypes.size() >= 72);
    chk("idle_frame_count", ok, 1'b1);
    if (ok) begin
      for (int i = 0; i < 8; i++) chk("rst_init_sync", ftypes[i], 1);
      for (int k = 0; k < 64; k++)
        chk("idle_pattern", ftypes[8 + k], ((k % 32) == 31) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_frame_serializer.md
Name: cmd_frame_serializer

Overview:
- FPGA-side command encoder directly upstream of the chip model's LVDS_CMD input, running on the same clock that drives LVDS_CMD_CLK.
- Accepts 16-bit command words over a valid/ready handshake and emits a continuous MSB-first serial stream, one bit per clock.
- Fills the gaps with SYNC and IDLE frames, and forces periodic SYNC frames so the chip's command decoder stays locked.

Parameters:
SYNC_WORD, 16'h817E, sync frame pattern
IDLE_WORD, 16'hAAAA, idle frame pattern
SYNC_PERIOD, 32, a SYNC frame is forced at least once every SYNC_PERIOD frames (legal range 2..255)
INIT_SYNCS, 8, number of back-to-back SYNC frames sent after reset release (legal range 1..255)

Ports:
CMD_CLK  in  1  command clock; also drives LVDS_CMD_CLK of the chip
RST  in  1  asynchronous active-high reset
DATA_IN  in  16  command word
DATA_VALID  in  1  DATA_IN holds a word to send
DATA_READY  out  1  one-cycle pulse: DATA_IN accepted this cycle
CMD_OUT  out  1  serial command stream, connects to LVDS_CMD
FRAME_START  out  1  pulse in the cycle CMD_OUT carries bit 15 of a new frame
FRAME_TYPE  out  2  type of the frame now on CMD_OUT: 0 idle, 1 sync, 2 data
INIT_DONE  out  1  high once all INIT_SYNCS frames have been sent
BUSY  out  1  high while a data frame is on CMD_OUT

Behaviour:
- Clocking and reset: one clock, CMD_CLK. RST is asynchronous and active-high.
- Values during RST: shift register = 0, bit_cnt = 15, sync_cnt = 0, init_cnt = 0.
  - Outputs: CMD_OUT=0, DATA_READY=0, FRAME_START=0, FRAME_TYPE=0, INIT_DONE=0, BUSY=0.
- Registers: shreg[15:0], bit_cnt (0..15), sync_cnt (frames since the last SYNC), init_cnt.
- CMD_OUT = shreg[15], driven directly from a flop; no combinational path from any input.
- Frame boundary: the clock edge where bit_cnt==15.
  - The next frame is loaded into shreg; bit_cnt wraps to 0.
  - FRAME_START and FRAME_TYPE are registered so they align with the first bit of the loaded frame.
- Away from the boundary: shreg shifts left by one with 0 fill; bit_cnt increments.
- Frame selection at each boundary, in priority order:
  1. Init: init_cnt < INIT_SYNCS -> SYNC; init_cnt++.
  2. Forced sync: sync_cnt >= SYNC_PERIOD-1 -> SYNC.
  3. Data: DATA_VALID=1 -> DATA_IN; DATA_READY=1 in this same cycle.
  4. Otherwise -> IDLE.
- sync_cnt: cleared when a SYNC frame loads; otherwise increments on every boundary (data and idle alike).
  - Never exceeds SYNC_PERIOD-1.
- DATA_READY is combinational from DATA_VALID, boundary, and "no init/forced sync this boundary".
  - It is high only in the boundary cycle, so there is at most one pulse per 16 cycles.
  - The source must hold DATA_VALID and DATA_IN stable until it sees DATA_READY.
  - If a forced sync wins the boundary, the word waits: DATA_READY stays low and the word is taken at the next boundary.
- INIT_DONE rises at the boundary where init_cnt reaches INIT_SYNCS, then stays high until RST.
- BUSY = (FRAME_TYPE==2).
- Latency: a word accepted at boundary cycle T appears with bit 15 on CMD_OUT at T+1 and bit 0 at T+16.
- Reset released mid-frame: the shift restarts cleanly.
  - The first edge after release is a boundary and loads SYNC #1.
  - No partial frame is ever emitted after reset.
- DATA_VALID toggling in non-boundary cycles has no effect; nothing is latched outside the boundary.

Test Plan:
- Reset release, DATA_VALID=0 -> FRAME_START at cycles 1,17,…; the first 8 frames are 0x817E MSB-first; INIT_DONE rises with frame 9; frame 9 is 0xAAAA.
- After INIT_DONE, DATA_IN=0x1234 with valid held -> DATA_READY one cycle at the next boundary; the next 16 CMD_OUT bits are 0001 0010 0011 0100; BUSY high for exactly 16 cycles.
- Words valid back-to-back for 100 frames with SYNC_PERIOD=32 -> a SYNC appears after every 31 non-sync frames; no word lost or duplicated (scoreboard compare); DATA_READY count = words sent.
- DATA_VALID rising at the boundary where a forced sync is due -> DATA_READY low, SYNC sent, word sent in the following frame.
- RST pulsed at bit 7 of a data frame -> CMD_OUT=0 and all outputs at reset values while RST high; after release, 8 fresh SYNC frames with no trailing data bits.
- Idle only for 64 frames -> the frame sequence is exactly (31 IDLE, 1 SYNC) repeating.
